// File: rtl/dtc_fe_pkg.sv
// Shared types and defaults for the DTC front-end ping-pong buffer.
package dtc_fe_pkg;

  localparam int DTC_NIBBLE_W = 4;
  localparam int DTC_PKT_LEN  = 64;

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

endpackage

// File: rtl/dtc_pp_bank.sv
// Simple dual-port RAM, one write port and one registered read port.
// Latency: 1 cycle from re/raddr to rdata.
// Backpressure: rdata holds while re is low, so the caller can stall a beat.
module dtc_pp_bank
  #(parameter int DATA_W = 4,
    parameter int DEPTH  = 128)
  (input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dtc_fe_pingpong.sv
// Ping-pong packet buffer: capture into one bank, drain the other (DTC_PP_STATS_EN adds counters).
// Latency: word 0 is presented the cycle after the completing write; 1 word/cycle thereafter.
// Backpressure: out_ready low freezes the output beat; a completion with a busy read side is dropped (ovf).
module dtc_fe_pingpong
  import dtc_fe_pkg::*;
  #(parameter int DATA_W  = DTC_NIBBLE_W,
    parameter int PKT_LEN = DTC_PKT_LEN,
    parameter int CNT_W   = 16)
  (input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_sop,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic              fill_bank,
   output logic              ovf,
   output logic [CNT_W-1:0]  pkt_count,
   output logic [CNT_W-1:0]  drop_count);

  localparam int            AW   = $clog2(PKT_LEN);
  localparam logic [AW-1:0] LAST = AW'(PKT_LEN - 1);

  wstate_t       w_state, w_state_nxt;
  rstate_t       r_state, r_state_nxt;
  logic [AW-1:0] wptr, wptr_nxt, rptr, rptr_nxt;
  logic          rd_bank, rd_bank_nxt, fill_nxt;
  logic          vld_nxt, sop_nxt, eop_nxt;
  logic          cmpl, swap, drop, xfer, eop_xfer, rd_free;
  logic          mem_we, mem_re;
  logic [AW:0]   mem_waddr, mem_raddr;

  assign xfer     = out_valid & out_ready;
  assign eop_xfer = xfer & out_eop;
  // The eop beat leaving in the same cycle frees the read side for a swap.
  assign rd_free  = (r_state == R_IDLE) | eop_xfer;
  assign swap     = cmpl & rd_free;
  assign drop     = cmpl & ~rd_free;
  assign fill_nxt = swap ? ~fill_bank : fill_bank;

  always_comb begin
    w_state_nxt = w_state;
    wptr_nxt    = wptr;
    mem_we      = 1'b0;
    mem_waddr   = {fill_bank, wptr};
    cmpl        = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (in_valid && in_sop) begin
          mem_we      = 1'b1;
          mem_waddr   = {fill_bank, {AW{1'b0}}};
          wptr_nxt    = AW'(1);
          w_state_nxt = W_FILL;
        end
      end
      W_FILL: begin
        if (in_valid) begin
          mem_we = 1'b1;
          if (in_sop) begin
            // Restart: the partial packet is abandoned in place.
            mem_waddr = {fill_bank, {AW{1'b0}}};
            wptr_nxt  = AW'(1);
          end else begin
            wptr_nxt = wptr + AW'(1);
            if (wptr == LAST) begin
              cmpl        = 1'b1;
              wptr_nxt    = '0;
              w_state_nxt = W_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    rptr_nxt    = rptr;
    rd_bank_nxt = rd_bank;
    vld_nxt     = out_valid;
    sop_nxt     = out_sop;
    eop_nxt     = out_eop;
    mem_re      = 1'b0;
    mem_raddr   = {rd_bank, rptr};
    if (swap) begin
      // Prefetch word 0 of the bank just completed.
      r_state_nxt = R_DRAIN;
      rd_bank_nxt = fill_bank;
      mem_re      = 1'b1;
      mem_raddr   = {fill_bank, {AW{1'b0}}};
      rptr_nxt    = AW'(1);
      vld_nxt     = 1'b1;
      sop_nxt     = 1'b1;
      eop_nxt     = 1'b0;
    end else if (eop_xfer) begin
      r_state_nxt = R_IDLE;
      rptr_nxt    = '0;
      vld_nxt     = 1'b0;
      sop_nxt     = 1'b0;
      eop_nxt     = 1'b0;
    end else if (xfer) begin
      mem_re   = 1'b1;
      rptr_nxt = rptr + AW'(1);
      sop_nxt  = 1'b0;
      eop_nxt  = (rptr == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      rd_bank   <= 1'b0;
      fill_bank <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      w_state   <= w_state_nxt;
      r_state   <= r_state_nxt;
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      rd_bank   <= rd_bank_nxt;
      fill_bank <= fill_nxt;
      out_valid <= vld_nxt;
      out_sop   <= sop_nxt;
      out_eop   <= eop_nxt;
      ovf       <= drop;
    end
  end

  dtc_pp_bank #(.DATA_W(DATA_W), .DEPTH(2 * PKT_LEN)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (in_data),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (out_data)
  );

`ifdef DTC_PP_STATS_EN
  logic             trunc;
  logic [CNT_W-1:0] pkt_q, drop_q;

  assign trunc = (w_state == W_FILL) & in_valid & in_sop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (eop_xfer && !(&pkt_q))          pkt_q  <= pkt_q + CNT_W'(1);
      if ((trunc || drop) && !(&drop_q)) drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule
